pipe_exec_mdu: RTL and testbench

PIPE_EXEC_MDU -- requirements
Module: pipe_exec_mdu

---
 rtl/pipe_exec_mdu.sv | 144 ++++++++++++++
 tb/tb_pipe_exec_mdu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_exec_mdu.sv
// pipe_exec_mdu: MIPS-style execute stage with forwarding muxes, a single-cycle ALU,
// a shift-add multiplier that stalls E, and the ID/EX and E/M pipeline registers.
module pipe_exec_mdu #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               validD,
    input  logic [WIDTH-1:0]   rd1D,
    input  logic [WIDTH-1:0]   rd2D,
    input  logic [WIDTH-1:0]   signimmD,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rdD,
    input  logic [2:0]         alucontrolD,
    input  logic               alusrcD,
    input  logic               regdstD,
    input  logic               mulD,
    input  logic               flushE,
    input  logic [1:0]         forwardaE,
    input  logic [1:0]         forwardbE,
    input  logic [WIDTH-1:0]   resultW,
    input  logic [WIDTH-1:0]   aluoutM,
    output logic               busyE,
    output logic [REGBITS-1:0] rsE,
    output logic [REGBITS-1:0] rtE,
    output logic               validM,
    output logic [WIDTH-1:0]   aluresultM,
    output logic [WIDTH-1:0]   writedataM,
    output logic [REGBITS-1:0] writeregM
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [WIDTH-1:0]   imm;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [2:0]         alucontrol;
        logic               alusrc;
        logic               regdst;
        logic               mul;
    } idex_t;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   result;
        logic [WIDTH-1:0]   wdata;
        logic [REGBITS-1:0] wreg;
    } exmem_t;

    idex_t            r_e;
    exmem_t           r_m;
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_prod;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_srca;
    logic [WIDTH-1:0] w_wde;
    logic [WIDTH-1:0] w_srcb;
    logic [WIDTH-1:0] w_alu;
    logic [REGBITS-1:0] w_wrege;
    logic             w_slt;
    logic             w_start;
    logic             w_bubble;

    assign w_srca  = forwardaE == 2'b01 ? resultW : forwardaE == 2'b10 ? aluoutM : r_e.rd1;
    assign w_wde   = forwardbE == 2'b01 ? resultW : forwardbE == 2'b10 ? aluoutM : r_e.rd2;
    assign w_srcb  = r_e.alusrc ? r_e.imm : w_wde;
    assign w_wrege = r_e.regdst ? r_e.rd : r_e.rt;
    assign w_slt   = $signed(w_srca) < $signed(w_srcb);

    always_comb begin
        w_alu = r_e.alucontrol == 3'b000 ? w_srca & w_srcb :
                r_e.alucontrol == 3'b001 ? w_srca | w_srcb :
                r_e.alucontrol == 3'b010 ? w_srca + w_srcb :
                r_e.alucontrol == 3'b110 ? w_srca - w_srcb :
                r_e.alucontrol == 3'b111 ? {{(WIDTH-1){1'b0}}, w_slt} : '0;
    end

    assign busyE = r_e.valid & r_e.mul & (r_state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // flush aborts a multiply from any state
    always_comb begin
        w_next = flushE             ? IDLE :
                 r_state == IDLE    ? ((r_e.valid & r_e.mul) ? MUL : IDLE) :
                 r_state == MUL     ? ((r_cnt == CW'(WIDTH-1)) ? DONE : MUL) : IDLE;
        w_start = (r_state == IDLE) & (w_next == MUL);
    end

    // r_opb stays unshifted so it can double as the store data sent to M
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa  <= '0;
            r_opb  <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (w_start) begin
            r_opa  <= w_srca;
            r_opb  <= w_wde;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (r_state == MUL) begin
            r_prod <= r_prod + (r_opb[r_cnt] ? (r_opa << r_cnt) : '0);
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_e <= '0;
        else if (flushE) r_e <= '0;
        else if (!busyE) r_e <= '{validD, rd1D, rd2D, signimmD, rsD, rtD, rdD,
                                   alucontrolD, alusrcD, regdstD, mulD};
    end

    assign w_bubble = (flushE & r_e.mul) | busyE | !r_e.valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_m <= '0;
        else if (w_bubble) r_m <= '0;
        else               r_m <= '{1'b1, r_e.mul ? r_prod : w_alu,
                                    r_e.mul ? r_opb : w_wde, w_wrege};
    end

    assign rsE        = r_e.rs;
    assign rtE        = r_e.rt;
    assign validM     = r_m.valid;
    assign aluresultM = r_m.result;
    assign writedataM = r_m.wdata;
    assign writeregM  = r_m.wreg;
endmodule

// File: tb/tb_pipe_exec_mdu.sv
// tb_pipe_exec_mdu: randomized and directed checks of pipe_exec_mdu against an
// arithmetic reference model of the execute stage and multiplier timing.
module tb_pipe_exec_mdu;
    logic        clk, reset, validD, alusrcD, regdstD, mulD, flushE;
    logic [31:0] rd1D, rd2D, signimmD, resultW, aluoutM;
    logic [4:0]  rsD, rtD, rdD;
    logic [2:0]  alucontrolD;
    logic [1:0]  forwardaE, forwardbE;
    logic        busyE, validM;
    logic [4:0]  rsE, rtE, writeregM;
    logic [31:0] aluresultM, writedataM;
    int          n_chk = 0;
    int          n_err = 0;

    pipe_exec_mdu #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .reset(reset), .validD(validD), .rd1D(rd1D), .rd2D(rd2D),
        .signimmD(signimmD), .rsD(rsD), .rtD(rtD), .rdD(rdD), .alucontrolD(alucontrolD),
        .alusrcD(alusrcD), .regdstD(regdstD), .mulD(mulD), .flushE(flushE),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .resultW(resultW), .aluoutM(aluoutM),
        .busyE(busyE), .rsE(rsE), .rtE(rtE), .validM(validM), .aluresultM(aluresultM),
        .writedataM(writedataM), .writeregM(writeregM)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, rw, am);
        return s == 2'd1 ? rw : s == 2'd2 ? am : r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, b);
        case (c)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_d(input logic v, input logic [31:0] r1, r2, imm,
                           input logic [4:0] rs, rt, rd, input logic [2:0] c,
                           input logic asrc, rdst, mul);
        validD = v; rd1D = r1; rd2D = r2; signimmD = imm; rsD = rs; rtD = rt; rdD = rd;
        alucontrolD = c; alusrcD = asrc; regdstD = rdst; mulD = mul;
    endtask

    task automatic run_alu(input logic [31:0] rd1, rd2, imm, input logic asrc,
                           input logic [2:0] c, input logic [1:0] fa, fb,
                           input logic [31:0] rw, am);
        logic [4:0]  rs, rt, rd;
        logic        rdst;
        logic [31:0] a, wd, b;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); rdst = 1'($urandom);
        drive_d(1'b1, rd1, rd2, imm, rs, rt, rd, c, asrc, rdst, 1'b0);
        @(posedge clk); #1;
        validD = 0;
        forwardaE = fa; forwardbE = fb; resultW = rw; aluoutM = am;
        a = fwd(fa, rd1, rw, am);
        wd = fwd(fb, rd2, rw, am);
        b = asrc ? imm : wd;
        chk("e_rs", 32'(rsE), 32'(rs));
        chk("e_busy", 32'(busyE), 32'd0);
        @(posedge clk); #1;
        chk("alu_res", aluresultM, ref_alu(c, a, b));
        chk("alu_wd", writedataM, wd);
        chk("alu_wr", 32'(writeregM), 32'(rdst ? rd : rt));
        chk("alu_vm", 32'(validM), 32'd1);
    endtask

    task automatic run_mul(input logic [31:0] rd1, rd2, input logic [1:0] fa, fb,
                           input logic [31:0] rw, am, input int flush_at);
        logic [4:0]  rs, rt, rd;
        logic        rdst, ok_vm, ok_hold, seen;
        logic [31:0] a, b, p;
        int          n;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); rdst = 1'($urandom);
        drive_d(1'b1, rd1, rd2, $urandom, rs, rt, rd, 3'b010, 1'b0, rdst, 1'b1);
        @(posedge clk); #1;
        validD = 0;
        forwardaE = fa; forwardbE = fb; resultW = rw; aluoutM = am;
        a = fwd(fa, rd1, rw, am);
        b = fwd(fb, rd2, rw, am);
        p = a * b;
        n = 0; ok_vm = 1; ok_hold = 1;
        while (busyE && n < 100) begin
            n++;
            if (validM) ok_vm = 0;
            if (rsE != rs || rtE != rt) ok_hold = 0;
            if (n == flush_at) flushE = 1;
            @(posedge clk); #1;
            flushE = 0;
            forwardaE = 2'($urandom); forwardbE = 2'($urandom);
            resultW = $urandom; aluoutM = $urandom;
            rsD = 5'($urandom); rtD = 5'($urandom); rd1D = $urandom;
        end
        chk("stall_vm", 32'(ok_vm), 32'd1);
        chk("stall_hold", 32'(ok_hold), 32'd1);
        if (flush_at == 0) begin
            chk("busy_len", n, 33);
            @(posedge clk); #1;
            chk("mul_res", aluresultM, p);
            chk("mul_wd", writedataM, b);
            chk("mul_wr", 32'(writeregM), 32'(rdst ? rd : rt));
            chk("mul_vm", 32'(validM), 32'd1);
            @(posedge clk); #1;
            chk("mul_vm_one", 32'(validM), 32'd0);
        end else begin
            chk("flush_len", n, flush_at);
            chk("flush_busy", 32'(busyE), 32'd0);
            seen = 0;
            repeat (40) begin
                if (validM || aluresultM == p) seen = 1;
                @(posedge clk); #1;
            end
            chk("flush_noprod", 32'(seen), 32'd0);
        end
    endtask

    initial begin
        logic seen;
        reset = 1; flushE = 0;
        forwardaE = 0; forwardbE = 0; resultW = 0; aluoutM = 0;
        drive_d(1'b0, 0, 0, 0, 0, 0, 0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_busy", 32'(busyE), 32'd0);
        chk("rst_vm", 32'(validM), 32'd0);
        chk("rst_res", aluresultM, 32'd0);
        #20;
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        run_alu(32'd5, 32'd7, 32'd0, 1'b0, 3'b010, 2'd0, 2'd0, 32'd0, 32'd0);
        run_alu(32'd0, 32'd1, 32'd0, 1'b0, 3'b010, 2'd2, 2'd0, 32'd0, 32'h10);
        run_alu(32'd0, 32'd1, 32'd0, 1'b0, 3'b110, 2'd2, 2'd1, 32'd3, 32'h10);
        run_alu(32'd0, 32'd1, 32'd0, 1'b0, 3'b110, 2'd0, 2'd0, 32'd0, 32'd0);
        run_alu(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b111, 2'd0, 2'd0, 32'd0, 32'd0);
        run_alu(32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'b111, 2'd0, 2'd0, 32'd0, 32'd0);
        run_alu(32'd9, 32'd0, 32'hFFFF_FFFC, 1'b1, 3'b010, 2'd0, 2'd3, 32'd0, 32'd0);
        repeat (40)
            run_alu($urandom, $urandom, $urandom, 1'($urandom), 3'($urandom),
                    2'($urandom), 2'($urandom), $urandom, $urandom);

        run_mul(32'h0000_FFFF, 32'h0001_0001, 2'd0, 2'd0, 32'd0, 32'd0, 0);
        run_mul(32'h0000_FFFF, 32'h0001_0001, 2'd0, 2'd0, 32'd0, 32'd0, 10);
        repeat (6)
            run_mul($urandom, $urandom, 2'($urandom), 2'($urandom), $urandom, $urandom, 0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'd0, 32'd0, 0);

        drive_d(1'b1, 32'h1234, 32'h5678, 0, 5'd3, 5'd4, 5'd5, 3'b010, 1'b0, 1'b0, 1'b1);
        forwardaE = 0; forwardbE = 0;
        @(posedge clk); #1;
        validD = 0;
        repeat (5) @(posedge clk);
        #2 reset = 1;
        #1;
        chk("mrst_busy", 32'(busyE), 32'd0);
        chk("mrst_vm", 32'(validM), 32'd0);
        chk("mrst_res", aluresultM, 32'd0);
        chk("mrst_wd", writedataM, 32'd0);
        chk("mrst_wr", 32'(writeregM), 32'd0);
        chk("mrst_rs", 32'({rsE, rtE}), 32'd0);
        #1 reset = 0;
        @(posedge clk); #1;
        seen = 0;
        repeat (40) begin
            if (validM || busyE) seen = 1;
            @(posedge clk); #1;
        end
        chk("mrst_noresult", 32'(seen), 32'd0);
        run_alu(32'd20, 32'd22, 32'd0, 1'b0, 3'b010, 2'd0, 2'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
